// File: rtl/button_conditioner.sv
// Two-channel push-button conditioner: 2-FF synchronizer, debouncer, clean level and press pulse.
// Optional macro BTN_REPEAT_EN adds hold-to-repeat pulses on the move (button) channel.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 21,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  input  logic button_rst,
  output logic button_level,
  output logic button_press,
  output logic button_rst_level,
  output logic button_rst_press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (2 ** CNT_W) - 1 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("button_conditioner: illegal debounce/repeat configuration");
  end

  logic [1:0] raw;
  logic [1:0] level;
  logic [1:0] press;
  logic [1:0] rise;
  logic [1:0] fall;
  logic       rep_pulse;

  assign raw = {button_rst, button};

  for (genvar i = 0; i < 2; i++) begin : g_ch
    logic             s1;
    logic             s2;
    logic             stable;
    logic             press_q;
    logic [CNT_W-1:0] cnt;
    logic             at_last;
    logic             extra;

    // s2 has disagreed with stable for DEBOUNCE_CYCLES-1 edges; this edge accepts it
    assign at_last = (s2 != stable) && (cnt == CNT_LAST);
    assign rise[i] = at_last && s2;
    assign fall[i] = at_last && !s2;
    assign extra   = (i == 0) ? rep_pulse : 1'b0;

    always_ff @(posedge clk) begin
      if (rst) begin
        s1      <= 1'b0;
        s2      <= 1'b0;
        stable  <= 1'b0;
        cnt     <= '0;
        press_q <= 1'b0;
      end else begin
        s1      <= raw[i];
        s2      <= s1;
        press_q <= rise[i] | extra;
        if (s2 == stable) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          stable <= s2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign level[i] = stable;
    assign press[i] = press_q;
  end

`ifdef BTN_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0] rep_cnt;
  logic             rep_armed;
  logic             rep_due;

  // First repeat waits REPEAT_DELAY after acceptance, later ones REPEAT_PERIOD
  assign rep_due   = rep_armed ? (rep_cnt == PERIOD_LAST) : (rep_cnt == DELAY_LAST);
  assign rep_pulse = level[0] && rep_due && !fall[0];

  always_ff @(posedge clk) begin
    if (rst || !level[0]) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
    end else if (rep_due) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b1;
    end else begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end
`else
  assign rep_pulse = 1'b0;
`endif

  assign button_level     = level[0];
  assign button_press     = press[0];
  assign button_rst_level = level[1];
  assign button_rst_press = press[1];

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: sliding-window reference model checked every cycle, plus directed scenarios.
module tb_button_conditioner;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic clk;
  logic rst;
  logic button;
  logic button_rst;
  logic button_level;
  logic button_press;
  logic button_rst_level;
  logic button_rst_press;

  int checks   = 0;
  int failures = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .button          (button),
    .button_rst      (button_rst),
    .button_level    (button_level),
    .button_press    (button_press),
    .button_rst_level(button_rst_level),
    .button_rst_press(button_rst_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: hist[j] holds the raw pair sampled j+1 edges ago; a level is accepted
  // when the raw samples 2..D+1 edges back all agree and differ from the level.
  logic [1:0] hist [0:D];
  logic [1:0] m_lvl;
  logic [1:0] m_press;
  int         tick;
  int         acc_t;
  logic       started = 1'b0;

  function automatic logic win_ok(input int c);
    logic v;
    v = hist[1][c];
    for (int j = 2; j <= D; j++)
      if (hist[j][c] != v) return 1'b0;
    return v != m_lvl[c];
  endfunction

  function automatic logic rep_due();
`ifdef BTN_REPEAT_EN
    int t;
    t = tick - acc_t;
    return m_lvl[0] && !win_ok(0) && (t >= RD) && (((t - RD) % RP) == 0);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    started <= 1'b1;
    tick    <= tick + 1;
    if (rst) begin
      for (int j = 0; j <= D; j++) hist[j] <= 2'b00;
      m_lvl   <= 2'b00;
      m_press <= 2'b00;
      acc_t   <= 0;
    end else begin
      hist[0] <= {button_rst, button};
      for (int j = 1; j <= D; j++) hist[j] <= hist[j-1];
      for (int c = 0; c < 2; c++)
        if (win_ok(c)) m_lvl[c] <= hist[1][c];
      m_press[1] <= win_ok(1) && hist[1][1];
      m_press[0] <= (win_ok(0) && hist[1][0]) || rep_due();
      if (win_ok(0) && hist[1][0]) acc_t <= tick;
    end
  end

  initial tick = 0;

  always @(negedge clk) begin
    if (started) begin
      checks++;
      if ({button_rst_press, button_rst_level, button_press, button_level} !==
          {m_press[1], m_lvl[1], m_press[0], m_lvl[0]}) begin
        failures++;
        $display("FAIL model_cycle t=%0t actual rp/rl/p/l=%b%b%b%b required=%b%b%b%b", $time,
                 button_rst_press, button_rst_level, button_press, button_level,
                 m_press[1], m_lvl[1], m_press[0], m_lvl[0]);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Plays bit k of each pattern before edge E0+k and samples after that edge.
  int pc, rpc, first_p, first_rp, rise_k, fall_k;
  task automatic play(input logic [63:0] pb, input logic [63:0] pr, input logic [63:0] prst,
                      input int n);
    logic prev;
    pc = 0; rpc = 0; first_p = -1; first_rp = -1; rise_k = -1; fall_k = -1;
    prev = button_level;
    for (int k = 0; k < n; k++) begin
      button     = pb[k];
      button_rst = pr[k];
      rst        = prst[k];
      @(negedge clk);
      if (button_press) begin pc++; if (first_p < 0) first_p = k; end
      if (button_rst_press) begin rpc++; if (first_rp < 0) first_rp = k; end
      if (!prev && button_level && rise_k < 0) rise_k = k;
      if (prev && !button_level && fall_k < 0) fall_k = k;
      prev = button_level;
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; button = 1'b1; button_rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_level",     int'(button_level), 0);
    chk("reset_press",     int'(button_press), 0);
    chk("reset_rst_level", int'(button_rst_level), 0);
    chk("reset_rst_press", int'(button_rst_press), 0);
    button = 1'b0; button_rst = 1'b0; rst = 1'b0;
    play(64'h0, 64'h0, 64'h0, 6);

    // Clean press held 8 cycles, then release
    play(64'hFF, 64'h0, 64'h0, 8);
    chk("clean_pulses", pc, 1);
    chk("clean_pulse_k", first_p, 5);
    chk("clean_level_k", rise_k, 5);
    chk("clean_rst_pulses", rpc, 0);
    play(64'h0, 64'h0, 64'h0, 10);
    chk("release_fall_k", fall_k, 5);
    chk("release_pulses", pc, 0);

    // Bounce: 3 high, 1 low, then high
    play(64'hFFF7, 64'h0, 64'h0, 16);
    chk("bounce_pulses", pc, 1);
    chk("bounce_pulse_k", first_p, 9);
    play(64'h0, 64'h0, 64'h0, 10);
    chk("bounce_release_k", fall_k, 5);

    // Glitch of D-1 ignored; pulse of exactly D accepted
    play(64'h7, 64'h0, 64'h0, 12);
    chk("glitch_pulses", pc, 0);
    chk("glitch_level", rise_k, -1);
    play(64'hF, 64'h0, 64'h0, 14);
    chk("minwidth_pulses", pc, 1);
    chk("minwidth_rise_k", rise_k, 5);
    chk("minwidth_fall_k", fall_k, 9);

    // Both buttons together
    play(64'hFF, 64'hFF, 64'h0, 8);
    chk("simul_p_k", first_p, 5);
    chk("simul_rp_k", first_rp, 5);
    chk("simul_rp_pulses", rpc, 1);
    play(64'h0, 64'h0, 64'h0, 10);
    chk("simul_rst_fall_k", fall_k, 5);

    // Reset at E0+3..E0+4 aborts the count; held button re-presses from R=E0+5
    play(64'h3FFF, 64'h0, 64'h18, 14);
    chk("rstmid_pulses", pc, 1);
    chk("rstmid_pulse_k", first_p, 10);
    chk("rstmid_rise_k", rise_k, 10);
    play(64'h0, 64'h0, 64'h0, 10);

    // Hold both for 40 cycles, then release
    play(64'hFF_FFFF_FFFF, 64'hFF_FFFF_FFFF, 64'h0, 52);
`ifdef BTN_REPEAT_EN
    chk("hold_pulses", pc, 7);
`else
    chk("hold_pulses", pc, 1);
`endif
    chk("hold_rst_pulses", rpc, 1);
    chk("hold_fall_k", fall_k, 45);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
